// File: rtl/sound_latch_bridge.sv
// rtl/sound_latch_bridge.sv - 68K to Z80 sound command latch with NMI and audio bank register
//
// Purpose: carries sound commands from the 68K to the Z80 on Alpha68K boards.
//   The 68K writes a byte; the Z80 reads it on any I/O read and clears it with
//   a write to port 0x00/0x01. A registered active-low NMI gives the Z80 one
//   falling edge per command. Also holds the Z80 audio bank register
//   (port 0x0E/0x0F, D[4:0]) that selects the 0xC000 ROM window.
//
// Build option: define SOUND_LATCH_FIFO_EN to queue FIFO_DEPTH commands.
//   Without it a single register is used, a new write overwrites an unread
//   byte, and latch_overflow is tied low.
//
// Ports:
//   clk, reset_n        clock (rising edge), asynchronous active-low reset
//   m68k_latch_cs       68K latch write select (level, qualified with !AS/!RW)
//   m68k_lds_n          68K lower data strobe; write only when low
//   m68k_dout[7:0]      68K data bus
//   z80_latch_cs        Z80 I/O read, any port
//   z80_latch_clr_cs    Z80 I/O write to port 0x00/0x01
//   z80_bank_set_cs     Z80 I/O write to port 0x0E/0x0F
//   z80_dout[7:0]       Z80 data bus out
//   latch_dout[7:0]     command byte to the Z80 data-in mux
//   bank_out[4:0]       audio ROM bank (0xC000 window = bank_out * 16KB)
//   latch_pending       command available
//   latch_overflow      sticky: a write was dropped because the FIFO was full
//   z80_nmi_n           Z80 NMI, active low, registered
module sound_latch_bridge #(
   parameter int FIFO_DEPTH  = 4,
   parameter bit CLR_ON_READ = 1'b1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       m68k_latch_cs,
   input  logic       m68k_lds_n,
   input  logic [7:0] m68k_dout,
   input  logic       z80_latch_cs,
   input  logic       z80_latch_clr_cs,
   input  logic       z80_bank_set_cs,
   input  logic [7:0] z80_dout,
   output logic [7:0] latch_dout,
   output logic [4:0] bank_out,
   output logic       latch_pending,
   output logic       latch_overflow,
   output logic       z80_nmi_n
);

   if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of 2 in 2..16");
   end

   // Selects are long levels; act once per bus cycle on the rising edge.
   logic m68k_cs_prev, rd_prev, clr_prev, bank_prev;
   logic wr_fire, rd_fire, clr_fire, bank_fire;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m68k_cs_prev <= 1'b0;
         rd_prev      <= 1'b0;
         clr_prev     <= 1'b0;
         bank_prev    <= 1'b0;
      end else begin
         m68k_cs_prev <= m68k_latch_cs;
         rd_prev      <= z80_latch_cs;
         clr_prev     <= z80_latch_clr_cs;
         bank_prev    <= z80_bank_set_cs;
      end
   end

   // lds_n is sampled only on the select edge: a late strobe loses the write.
   assign wr_fire   = m68k_latch_cs & ~m68k_cs_prev & ~m68k_lds_n;
   assign rd_fire   = z80_latch_cs & ~rd_prev;
   assign clr_fire  = z80_latch_clr_cs & ~clr_prev;
   assign bank_fire = z80_bank_set_cs & ~bank_prev;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bank_out <= 5'd0;
      end else if (bank_fire) begin
         bank_out <= z80_dout[4:0];
      end
   end

   logic unused_bank_bits;
   assign unused_bank_bits = &{1'b0, z80_dout[7:5]};

   logic       pending;
   logic       pending_next;
   logic       consume;
   logic       gap_q, gap_next;
   logic [7:0] dout_q, dout_next;
   logic       nmi_q;

`ifdef SOUND_LATCH_FIFO_EN
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int PTR_W = AW + 1;

   logic [7:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [PTR_W-1:0] rd_base, rd_next, wr_next;
   logic             full_after_rd, push, drop;
   logic             overflow_q;
   logic [7:0]       head_next;

   // Order within one clock: clear flushes, then a read frees a slot, then the write.
   always_comb begin
      rd_base       = clr_fire ? wr_ptr : rd_ptr;
      consume       = rd_fire & CLR_ON_READ & (rd_base != wr_ptr);
      rd_next       = rd_base + {{AW{1'b0}}, consume};
      full_after_rd = (wr_ptr - rd_next) == PTR_W'(FIFO_DEPTH);
      push          = wr_fire & ~full_after_rd;
      drop          = wr_fire & full_after_rd;
      wr_next       = wr_ptr + {{AW{1'b0}}, push};
      pending_next  = (wr_next != rd_next);
      // Slots can only coincide when the FIFO was empty, so the pushed byte is the head.
      if (push && (wr_ptr[AW-1:0] == rd_next[AW-1:0])) begin
         head_next = m68k_dout;
      end else begin
         head_next = mem[rd_next[AW-1:0]];
      end
      // An empty FIFO keeps showing the last consumed byte.
      if (pending_next) begin
         dout_next = head_next;
      end else if (clr_fire) begin
         dout_next = 8'h00;
      end else begin
         dout_next = dout_q;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr     <= wr_next;
         rd_ptr     <= rd_next;
         overflow_q <= (overflow_q & ~clr_fire) | drop;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= m68k_dout;
      end
   end

   assign pending        = (wr_ptr != rd_ptr);
   assign latch_overflow = overflow_q;
`else
   logic pending_q;

   always_comb begin
      consume      = rd_fire & CLR_ON_READ & pending_q & ~clr_fire;
      pending_next = wr_fire | (pending_q & ~clr_fire & ~consume);
      if (wr_fire) begin
         dout_next = m68k_dout;
      end else if (clr_fire) begin
         dout_next = 8'h00;
      end else begin
         dout_next = dout_q;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pending_q <= 1'b0;
      end else begin
         pending_q <= pending_next;
      end
   end

   assign pending        = pending_q;
   assign latch_overflow = 1'b0;
`endif

   // gap marks a consume that leaves another command waiting, so NMI deasserts
   // for one clock and the edge-triggered Z80 sees a fresh falling edge.
   assign gap_next = consume & pending_next;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dout_q <= 8'h00;
         gap_q  <= 1'b0;
         nmi_q  <= 1'b1;
      end else begin
         dout_q <= dout_next;
         gap_q  <= gap_next;
         nmi_q  <= ~(pending & ~gap_q);
      end
   end

   assign latch_dout    = dout_q;
   assign latch_pending = pending;
   assign z80_nmi_n     = nmi_q;

endmodule

// File: tb/tb_sound_latch_bridge.sv
// tb/tb_sound_latch_bridge.sv - directed self-checking bench for sound_latch_bridge
module tb_sound_latch_bridge;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       m68k_latch_cs;
   logic       m68k_lds_n;
   logic [7:0] m68k_dout;
   logic       z80_latch_cs;
   logic       z80_latch_clr_cs;
   logic       z80_bank_set_cs;
   logic [7:0] z80_dout;
   logic [7:0] latch_dout;
   logic [4:0] bank_out;
   logic       latch_pending;
   logic       latch_overflow;
   logic       z80_nmi_n;

   int vectors = 0;
   int errors  = 0;

   always #5 clk = ~clk;

   sound_latch_bridge dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .m68k_latch_cs    (m68k_latch_cs),
      .m68k_lds_n       (m68k_lds_n),
      .m68k_dout        (m68k_dout),
      .z80_latch_cs     (z80_latch_cs),
      .z80_latch_clr_cs (z80_latch_clr_cs),
      .z80_bank_set_cs  (z80_bank_set_cs),
      .z80_dout         (z80_dout),
      .latch_dout       (latch_dout),
      .bank_out         (bank_out),
      .latch_pending    (latch_pending),
      .latch_overflow   (latch_overflow),
      .z80_nmi_n        (z80_nmi_n)
   );

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic m68k_write(input logic [7:0] b);
      m68k_dout = b; m68k_lds_n = 1'b0; m68k_latch_cs = 1'b1;
      tick(4);
      m68k_latch_cs = 1'b0; m68k_lds_n = 1'b1;
      tick(2);
   endtask

   task automatic z80_clear();
      z80_latch_clr_cs = 1'b1;
      tick(3);
      z80_latch_clr_cs = 1'b0;
      tick(2);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      m68k_latch_cs = 0; m68k_lds_n = 1; m68k_dout = 0;
      z80_latch_cs = 0; z80_latch_clr_cs = 0; z80_bank_set_cs = 0; z80_dout = 0;
      tick(3);
      vectors++;
      if ({latch_dout, bank_out, latch_pending, latch_overflow, z80_nmi_n} !== {8'h00, 5'h00, 1'b0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL reset_por got dout=%h bank=%h pend=%b ovf=%b nmi_n=%b want 00/00/0/0/1",
                  latch_dout, bank_out, latch_pending, latch_overflow, z80_nmi_n);
      end
      reset_n = 1'b1;
      tick(2);
      // Build some state, then reset in the middle of a held write select.
      m68k_write(8'h77);
      z80_dout = 8'h05; z80_bank_set_cs = 1'b1; tick(2); z80_bank_set_cs = 1'b0;
      m68k_dout = 8'h99; m68k_lds_n = 1'b0; m68k_latch_cs = 1'b1;
      tick(1);
      reset_n = 1'b0;
      #2;
      vectors++;
      if ({latch_dout, bank_out, latch_pending, latch_overflow, z80_nmi_n} !== {8'h00, 5'h00, 1'b0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL reset_mid got dout=%h bank=%h pend=%b ovf=%b nmi_n=%b want 00/00/0/0/1",
                  latch_dout, bank_out, latch_pending, latch_overflow, z80_nmi_n);
      end
      m68k_latch_cs = 1'b0; m68k_lds_n = 1'b1;
      tick(2);
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick(1);
         vectors++;
         if (z80_nmi_n !== 1'b1 || latch_pending !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_quiet cycle %0d got nmi_n=%b pend=%b want 1/0", i, z80_nmi_n, latch_pending);
         end
      end
   endtask

   task automatic test_write();
      m68k_dout = 8'h5A; m68k_lds_n = 1'b0; m68k_latch_cs = 1'b1;
      tick(1);
      vectors++;
      if (latch_dout !== 8'h5A || latch_pending !== 1'b1 || z80_nmi_n !== 1'b1) begin
         errors++;
         $display("FAIL write_first_clk got dout=%h pend=%b nmi_n=%b want 5a/1/1", latch_dout, latch_pending, z80_nmi_n);
      end
      tick(1);
      vectors++;
      if (z80_nmi_n !== 1'b0) begin
         errors++;
         $display("FAIL write_nmi_latency got nmi_n=%b want 0", z80_nmi_n);
      end
      tick(4);
      m68k_latch_cs = 1'b0; m68k_lds_n = 1'b1;
      tick(2);
      vectors++;
      if (latch_dout !== 8'h5A || latch_pending !== 1'b1 || z80_nmi_n !== 1'b0) begin
         errors++;
         $display("FAIL write_hold got dout=%h pend=%b nmi_n=%b want 5a/1/0", latch_dout, latch_pending, z80_nmi_n);
      end
   endtask

   task automatic test_read_clear();
      z80_latch_cs = 1'b1;
      tick(2);
      vectors++;
      if (latch_dout !== 8'h5A || latch_pending !== 1'b0 || z80_nmi_n !== 1'b1) begin
         errors++;
         $display("FAIL read_consume got dout=%h pend=%b nmi_n=%b want 5a/0/1", latch_dout, latch_pending, z80_nmi_n);
      end
      z80_latch_cs = 1'b0;
      tick(2);
      z80_latch_clr_cs = 1'b1;
      tick(1);
      vectors++;
      if (latch_dout !== 8'h00 || latch_pending !== 1'b0) begin
         errors++;
         $display("FAIL clear_port got dout=%h pend=%b want 00/0", latch_dout, latch_pending);
      end
      z80_latch_clr_cs = 1'b0;
      tick(2);
   endtask

   task automatic test_lds_late();
      m68k_dout = 8'hC3; m68k_lds_n = 1'b1; m68k_latch_cs = 1'b1;
      tick(1);
      m68k_lds_n = 1'b0;
      tick(3);
      m68k_latch_cs = 1'b0; m68k_lds_n = 1'b1;
      tick(2);
      vectors++;
      if (latch_dout !== 8'h00 || latch_pending !== 1'b0 || z80_nmi_n !== 1'b1) begin
         errors++;
         $display("FAIL lds_late got dout=%h pend=%b nmi_n=%b want 00/0/1", latch_dout, latch_pending, z80_nmi_n);
      end
   endtask

   task automatic test_write_clear_same();
      m68k_dout = 8'h11; m68k_lds_n = 1'b0; m68k_latch_cs = 1'b1; z80_latch_clr_cs = 1'b1;
      tick(1);
      vectors++;
      if (latch_dout !== 8'h11 || latch_pending !== 1'b1) begin
         errors++;
         $display("FAIL write_clear_same got dout=%h pend=%b want 11/1", latch_dout, latch_pending);
      end
      tick(2);
      m68k_latch_cs = 1'b0; m68k_lds_n = 1'b1; z80_latch_clr_cs = 1'b0;
      tick(2);
   endtask

   task automatic test_bank();
      z80_dout = 8'hF3; z80_bank_set_cs = 1'b1;
      tick(1);
      z80_dout = 8'h0A;
      tick(2);
      vectors++;
      if (bank_out !== 5'h13 || latch_dout !== 8'h11 || latch_pending !== 1'b1) begin
         errors++;
         $display("FAIL bank_set got bank=%h dout=%h pend=%b want 13/11/1", bank_out, latch_dout, latch_pending);
      end
      z80_bank_set_cs = 1'b0;
      tick(2);
   endtask

   task automatic test_write_read_same();
      m68k_dout = 8'h22; m68k_lds_n = 1'b0; m68k_latch_cs = 1'b1; z80_latch_cs = 1'b1;
      tick(1);
      vectors++;
      if (latch_dout !== 8'h22 || latch_pending !== 1'b1 || z80_nmi_n !== 1'b0) begin
         errors++;
         $display("FAIL write_read_same got dout=%h pend=%b nmi_n=%b want 22/1/0", latch_dout, latch_pending, z80_nmi_n);
      end
      tick(1);
      vectors++;
      if (z80_nmi_n !== 1'b1) begin
         errors++;
         $display("FAIL write_read_gap got nmi_n=%b want 1", z80_nmi_n);
      end
      tick(1);
      vectors++;
      if (z80_nmi_n !== 1'b0) begin
         errors++;
         $display("FAIL write_read_renmi got nmi_n=%b want 0", z80_nmi_n);
      end
      m68k_latch_cs = 1'b0; m68k_lds_n = 1'b1; z80_latch_cs = 1'b0;
      tick(2);
      z80_clear();
   endtask

`ifdef SOUND_LATCH_FIFO_EN
   task automatic test_fifo();
      logic [7:0] exp_next;
      for (int i = 1; i <= 5; i++) m68k_write(8'(i));
      vectors++;
      if (latch_overflow !== 1'b1 || latch_dout !== 8'h01 || latch_pending !== 1'b1 || z80_nmi_n !== 1'b0) begin
         errors++;
         $display("FAIL fifo_fill got ovf=%b dout=%h pend=%b nmi_n=%b want 1/01/1/0",
                  latch_overflow, latch_dout, latch_pending, z80_nmi_n);
      end
      for (int i = 1; i <= 4; i++) begin
         vectors++;
         if (latch_dout !== 8'(i)) begin
            errors++;
            $display("FAIL fifo_read_data %0d got %h want %h", i, latch_dout, 8'(i));
         end
         exp_next = (i < 4) ? 8'(i + 1) : 8'd4;
         z80_latch_cs = 1'b1;
         tick(1);
         vectors++;
         if (latch_dout !== exp_next || z80_nmi_n !== 1'b0) begin
            errors++;
            $display("FAIL fifo_advance %0d got dout=%h nmi_n=%b want %h/0", i, latch_dout, z80_nmi_n, exp_next);
         end
         tick(1);
         vectors++;
         if (z80_nmi_n !== 1'b1) begin
            errors++;
            $display("FAIL fifo_gap %0d got nmi_n=%b want 1", i, z80_nmi_n);
         end
         tick(1);
         vectors++;
         if (z80_nmi_n !== ((i < 4) ? 1'b0 : 1'b1)) begin
            errors++;
            $display("FAIL fifo_renmi %0d got nmi_n=%b want %b", i, z80_nmi_n, (i < 4) ? 1'b0 : 1'b1);
         end
         z80_latch_cs = 1'b0;
         tick(2);
      end
      z80_latch_cs = 1'b1; tick(2); z80_latch_cs = 1'b0; tick(2);
      vectors++;
      if (latch_pending !== 1'b0 || latch_dout !== 8'h04 || latch_overflow !== 1'b1 || z80_nmi_n !== 1'b1) begin
         errors++;
         $display("FAIL fifo_read_empty got pend=%b dout=%h ovf=%b nmi_n=%b want 0/04/1/1",
                  latch_pending, latch_dout, latch_overflow, z80_nmi_n);
      end
      z80_clear();
      vectors++;
      if (latch_overflow !== 1'b0 || latch_dout !== 8'h00) begin
         errors++;
         $display("FAIL fifo_clear got ovf=%b dout=%h want 0/00", latch_overflow, latch_dout);
      end
   endtask
`else
   task automatic test_overwrite();
      for (int i = 1; i <= 5; i++) m68k_write(8'(i));
      vectors++;
      if (latch_dout !== 8'h05 || latch_pending !== 1'b1 || latch_overflow !== 1'b0 || z80_nmi_n !== 1'b0) begin
         errors++;
         $display("FAIL overwrite got dout=%h pend=%b ovf=%b nmi_n=%b want 05/1/0/0",
                  latch_dout, latch_pending, latch_overflow, z80_nmi_n);
      end
      z80_latch_cs = 1'b1; tick(2); z80_latch_cs = 1'b0; tick(2);
      vectors++;
      if (latch_dout !== 8'h05 || latch_pending !== 1'b0 || z80_nmi_n !== 1'b1) begin
         errors++;
         $display("FAIL overwrite_read got dout=%h pend=%b nmi_n=%b want 05/0/1", latch_dout, latch_pending, z80_nmi_n);
      end
      z80_clear();
   endtask
`endif

   initial begin
      test_reset();
      test_write();
      test_read_clear();
      test_lds_late();
      test_write_clear_same();
      test_bank();
      test_write_read_same();
`ifdef SOUND_LATCH_FIFO_EN
      test_fifo();
`else
      test_overwrite();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
